// File: rtl/eth_pkg.sv
// Ethernet constants shared across the MAC receive slice, plus the
// bytewise reflected CRC-32 step used by the FCS datapath.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   // One byte through the reflected register, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                              input logic [7:0]  data_in);
      logic [31:0] c;
      c = crc_in ^ {24'h0, data_in};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_upd64.sv
// Combinational CRC-32 update over the first nbytes (1..8) of a 64-bit beat,
// byte 0 on data[7:0].
module eth_crc32_upd64
   import eth_pkg::*;
(
   input  logic [31:0] seed,
   input  logic [63:0] data,
   input  logic [3:0]  nbytes,
   output logic [31:0] crc
);

   always_comb begin
      crc = seed;
      for (int b = 0; b < 8; b++)
         if (4'(b) < nbytes) crc = crc32_byte(crc, data[8*b +: 8]);
   end

endmodule

// File: rtl/eth_fcs_chk.sv
// Ethernet FCS checker: strips the trailing 4 FCS bytes from a 64-bit beat
// stream and reports per-frame CRC, runt and abort status.
module eth_fcs_chk
   import eth_pkg::*;
#(
   parameter logic [31:0] CRC_INIT    = CRC32_INIT,
   parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic [63:0] in_data,
   input  logic [2:0]  in_be,
   output logic        out_vld,
   output logic        out_sop,
   output logic        out_eop,
   output logic [63:0] out_data,
   output logic [2:0]  out_be,
   output logic        stat_vld,
   output logic        stat_crc_err,
   output logic        stat_runt,
   output logic        stat_abort
);

   logic        in_frame;
   logic        sop_p0;
   logic [63:0] data_p0;
   logic [31:0] crc_p0;

   logic        vld_p1;
   logic        dvld_p1;
   logic        sop_p1;
   logic        err_p1;
   logic        runt_p1;
   logic [2:0]  be_p1;
   logic [63:0] data_p1;

   logic        beat;
   logic        short_eop;
   logic        tail;
   logic        tail_now;
   logic        tail_runt;
   logic        tail_err;
   logic        crc_bad;
   logic [3:0]  nbytes;
   logic [31:0] crc_seed;
   logic [31:0] crc_nxt;
   logic [2:0]  trim_be;
   logic [2:0]  keep_be;

   assign beat      = in_vld && (in_sop || in_frame);
   // A short EOP beat holds only FCS bytes, so the held beat becomes the last.
   assign short_eop = in_eop && (in_be != 3'd0) && (in_be <= 3'd4);
   assign nbytes    = (in_eop && in_be != 3'd0) ? {1'b0, in_be} : 4'd8;
   assign crc_seed  = in_sop ? CRC_INIT : crc_p0;
   assign trim_be   = in_be - 3'd4;
   assign keep_be   = in_be + 3'd4;
   assign crc_bad   = (crc_nxt != CRC_RESIDUE);
   // The EOP beat itself yields output/status unless a held beat absorbs it.
   assign tail      = in_eop && (in_sop || !short_eop);
   assign tail_now  = in_sop && !in_frame;
   assign tail_runt = in_sop && short_eop;
   assign tail_err  = tail_runt || crc_bad;

   eth_crc32_upd64 u_crc (
      .seed   (crc_seed),
      .data   (in_data),
      .nbytes (nbytes),
      .crc    (crc_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_frame     <= 1'b0;
         sop_p0       <= 1'b0;
         crc_p0       <= CRC_INIT;
         vld_p1       <= 1'b0;
         dvld_p1      <= 1'b0;
         sop_p1       <= 1'b0;
         err_p1       <= 1'b0;
         runt_p1      <= 1'b0;
         be_p1        <= 3'd0;
         out_vld      <= 1'b0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         out_data     <= 64'd0;
         out_be       <= 3'd0;
         stat_vld     <= 1'b0;
         stat_crc_err <= 1'b0;
         stat_runt    <= 1'b0;
         stat_abort   <= 1'b0;
      end else begin
         out_vld      <= 1'b0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         stat_vld     <= 1'b0;
         stat_crc_err <= 1'b0;
         stat_runt    <= 1'b0;
         stat_abort   <= 1'b0;
         vld_p1       <= 1'b0;

         // p1 -> output: trimmed last beat (or deferred status) one cycle late
         if (vld_p1) begin
            out_vld      <= dvld_p1;
            out_sop      <= sop_p1 && dvld_p1;
            out_eop      <= dvld_p1;
            out_data     <= data_p1;
            out_be       <= be_p1;
            stat_vld     <= 1'b1;
            stat_crc_err <= err_p1;
            stat_runt    <= runt_p1;
         end

         if (beat) begin
            // p0 -> output: release the held beat
            if (in_frame) begin
               out_vld  <= 1'b1;
               out_sop  <= sop_p0;
               out_eop  <= 1'b0;
               out_data <= data_p0;
               out_be   <= 3'd0;
               if (in_sop) begin
                  out_eop      <= 1'b1;
                  stat_vld     <= 1'b1;
                  stat_crc_err <= 1'b1;
                  stat_abort   <= 1'b1;
               end else if (short_eop) begin
                  out_eop      <= 1'b1;
                  out_be       <= keep_be;
                  stat_vld     <= 1'b1;
                  stat_crc_err <= crc_bad;
               end
            end

            // input -> p0 / p1
            if (!in_eop) begin
               in_frame <= 1'b1;
               sop_p0   <= in_sop;
               data_p0  <= in_data;
               crc_p0   <= crc_nxt;
            end else begin
               in_frame <= 1'b0;
               crc_p0   <= CRC_INIT;
               if (tail && tail_now) begin
                  out_vld      <= !short_eop;
                  out_sop      <= !short_eop;
                  out_eop      <= !short_eop;
                  out_data     <= in_data;
                  out_be       <= trim_be;
                  stat_vld     <= 1'b1;
                  stat_crc_err <= tail_err;
                  stat_runt    <= tail_runt;
               end else if (tail) begin
                  vld_p1  <= 1'b1;
                  dvld_p1 <= !short_eop;
                  sop_p1  <= in_sop;
                  data_p1 <= in_data;
                  be_p1   <= trim_be;
                  err_p1  <= tail_err;
                  runt_p1 <= tail_runt;
               end
            end
         end
      end
   end

endmodule
